// File: rtl/wb_decoder_1m_ns.sv
// wb_decoder_1m_ns: routes one Wishbone classic master to NUM_SLAVES slaves.
// The slave is chosen by m_addr_i[SEL_LSB +: SEL_BITS] and locked for the whole
// bus cycle. Unmapped addresses, a select change inside a cycle and a stalled
// access (watchdog) are all terminated with a one-cycle error.
// Optional feature: define WB_DECODER_ERR_CAPTURE_EN to add err_addr_o and
// err_cause_o, which record the address and cause of decoder-generated errors.
module wb_decoder_1m_ns #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_SLAVES = 4,
  parameter int SEL_BITS   = 2,
  parameter int SEL_LSB    = 24,
  parameter int SLAVE_AW   = 24,
  parameter int TIMEOUT    = 255
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic [ADDR_WIDTH-1:0]              m_addr_i,
  input  logic [DATA_WIDTH-1:0]              m_data_i,
  output logic [DATA_WIDTH-1:0]              m_data_o,
  input  logic                               m_cyc_i,
  input  logic                               m_stb_i,
  input  logic                               m_we_i,
  input  logic [DATA_WIDTH/8-1:0]            m_sel_i,
  output logic                               m_ack_o,
  output logic                               m_err_o,
  output logic                               m_rty_o,
  output logic [NUM_SLAVES*SLAVE_AW-1:0]     s_addr_o,
  output logic [NUM_SLAVES*DATA_WIDTH-1:0]   s_data_o,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0]   s_data_i,
  output logic [NUM_SLAVES*DATA_WIDTH/8-1:0] s_sel_o,
  output logic [NUM_SLAVES-1:0]              s_cyc_o,
  output logic [NUM_SLAVES-1:0]              s_stb_o,
  output logic [NUM_SLAVES-1:0]              s_we_o,
  input  logic [NUM_SLAVES-1:0]              s_ack_i,
  input  logic [NUM_SLAVES-1:0]              s_err_i,
  input  logic [NUM_SLAVES-1:0]              s_rty_i
`ifdef WB_DECODER_ERR_CAPTURE_EN
  ,
  output logic [ADDR_WIDTH-1:0]              err_addr_o,
  output logic [1:0]                         err_cause_o
`endif
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ACTIVE, ERR} state_t;

  state_t              state, state_nxt;
  logic [SEL_BITS-1:0] idx, sel, lock_idx, lock_nxt;
  logic [CW-1:0]       cnt, cnt_nxt, cnt_inc;
  logic                err_pend, err_pend_nxt;
  logic                idx_valid, launch, routed, cyc_ok;
  logic                sel_change, decode_err, wdog_err, term;
  logic                sel_ack, sel_err, sel_rty;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                addr_unused;

  // Upper address bits outside the select field and slave window only matter for capture.
  assign addr_unused = ^m_addr_i;

  assign idx       = m_addr_i[SEL_LSB +: SEL_BITS];
  assign idx_valid = ({1'b0, idx} < (SEL_BITS+1)'(NUM_SLAVES));
  assign sel       = (state == IDLE) ? idx : lock_idx;

  // A launch is the IDLE cycle that hands a valid strobe straight to the slave.
  assign launch     = (state == IDLE) && m_cyc_i && m_stb_i && idx_valid;
  assign decode_err = (state == IDLE) && m_cyc_i && m_stb_i && !idx_valid;
  assign sel_change = (state == ACTIVE) && m_cyc_i && m_stb_i && (idx != lock_idx);
  assign routed     = !rst_i && ((state == ACTIVE) || launch);
  assign cyc_ok     = !rst_i && m_cyc_i &&
                      (((state == IDLE) && idx_valid) || (state == ACTIVE));

  // Saturating increment so the watchdog can never wrap back to zero.
  assign cnt_inc  = (cnt == CW'(TIMEOUT)) ? cnt : cnt + 1'b1;
  assign term     = sel_ack || sel_err || sel_rty;
  assign wdog_err = (state == ACTIVE) && m_cyc_i && m_stb_i && !sel_change &&
                    !term && (cnt_inc == CW'(TIMEOUT));

  // Address, write data and byte selects go to every slave unqualified.
  assign s_addr_o = {NUM_SLAVES{m_addr_i[SLAVE_AW-1:0]}};
  assign s_data_o = {NUM_SLAVES{m_data_i}};
  assign s_sel_o  = {NUM_SLAVES{m_sel_i}};

  // Pick the response signals of the currently selected slave; out-of-range selects read as idle.
  always_comb begin
    sel_ack  = 1'b0;
    sel_err  = 1'b0;
    sel_rty  = 1'b0;
    sel_data = '0;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      if (sel == SEL_BITS'(k)) begin
        sel_ack  = s_ack_i[k];
        sel_err  = s_err_i[k];
        sel_rty  = s_rty_i[k];
        sel_data = s_data_i[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Qualify cycle/strobe/write-enable to the selected slave; a select change hides the strobe.
  always_comb begin
    s_cyc_o = '0;
    s_stb_o = '0;
    s_we_o  = '0;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      if (cyc_ok && (sel == SEL_BITS'(k))) begin
        s_cyc_o[k] = 1'b1;
        s_stb_o[k] = m_stb_i && !sel_change;
        s_we_o[k]  = m_we_i;
      end
    end
  end

  assign m_data_o = routed ? sel_data : '0;
  assign m_ack_o  = routed && sel_ack;
  assign m_rty_o  = routed && sel_rty;
  assign m_err_o  = (routed && sel_err) || err_pend;

  // Next-state logic: lock on launch, count stalled strobes, divert all decoder errors to ERR.
  always_comb begin
    state_nxt    = state;
    lock_nxt     = lock_idx;
    cnt_nxt      = cnt;
    err_pend_nxt = 1'b0;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (launch) begin
          state_nxt = ACTIVE;
          lock_nxt  = idx;
        end else if (decode_err) begin
          state_nxt    = ERR;
          err_pend_nxt = 1'b1;
        end
      end
      ACTIVE: begin
        if (!m_cyc_i) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (sel_change || wdog_err) begin
          state_nxt    = ERR;
          err_pend_nxt = 1'b1;
          cnt_nxt      = '0;
        end else if (term) begin
          cnt_nxt = '0;
        end else if (m_stb_i) begin
          cnt_nxt = cnt_inc;
        end
      end
      ERR: begin
        cnt_nxt = '0;
        if (!m_stb_i || !m_cyc_i) state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // State, locked select, watchdog and pending-error registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= IDLE;
      lock_idx <= '0;
      cnt      <= '0;
      err_pend <= 1'b0;
    end else begin
      state    <= state_nxt;
      lock_idx <= lock_nxt;
      cnt      <= cnt_nxt;
      err_pend <= err_pend_nxt;
    end
  end

`ifdef WB_DECODER_ERR_CAPTURE_EN
  // Record address and cause of decoder-generated errors; slave errors are not captured.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_addr_o  <= '0;
      err_cause_o <= 2'b00;
    end else if (decode_err) begin
      err_addr_o  <= m_addr_i;
      err_cause_o <= 2'b01;
    end else if (sel_change) begin
      err_addr_o  <= m_addr_i;
      err_cause_o <= 2'b10;
    end else if (wdog_err) begin
      err_addr_o  <= m_addr_i;
      err_cause_o <= 2'b11;
    end
  end
`endif

endmodule

// File: tb/tb_wb_decoder_1m_ns.sv
// tb_wb_decoder_1m_ns: directed scenarios plus randomized bus cycles for
// wb_decoder_1m_ns (3 slaves, watchdog of 8), checked against a transaction-level model.
module tb_wb_decoder_1m_ns;

  localparam int NSL = 3;
  localparam int TMO = 8;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic [31:0] m_addr_i = '0;
  logic [31:0] m_data_i = '0;
  logic [31:0] m_data_o;
  logic        m_cyc_i = 1'b0, m_stb_i = 1'b0, m_we_i = 1'b0;
  logic [3:0]  m_sel_i = '0;
  logic        m_ack_o, m_err_o, m_rty_o;
  logic [71:0] s_addr_o;
  logic [95:0] s_data_o;
  logic [95:0] s_data_i = '0;
  logic [11:0] s_sel_o;
  logic [2:0]  s_cyc_o, s_stb_o, s_we_o;
  logic [2:0]  s_ack_i = '0, s_err_i = '0, s_rty_i = '0;
`ifdef WB_DECODER_ERR_CAPTURE_EN
  logic [31:0] err_addr_o;
  logic [1:0]  err_cause_o;
  logic [31:0] mdl_cap_addr = '0;
  logic [1:0]  mdl_cap_cause = '0;
`endif

  int tests_run = 0;
  int tests_failed = 0;
  bit checking = 1'b0;
  bit fixed_data = 1'b0;

  // Model of the bus: who owns the current cycle (-1 = nobody), error handshake, stalled strobes.
  int mdl_owner = -1;
  bit mdl_inerr = 1'b0;
  bit mdl_errflag = 1'b0;
  int mdl_waits = 0;

  logic [2:0]  exp_cyc, exp_stb, exp_we;
  logic [31:0] exp_mdata;
  logic        exp_ack, exp_err, exp_rty;

  wb_decoder_1m_ns #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_SLAVES(NSL), .SEL_BITS(2),
    .SEL_LSB(24), .SLAVE_AW(24), .TIMEOUT(TMO)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .m_addr_i(m_addr_i), .m_data_i(m_data_i), .m_data_o(m_data_o),
    .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i), .m_sel_i(m_sel_i),
    .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_rty_o(m_rty_o),
    .s_addr_o(s_addr_o), .s_data_o(s_data_o), .s_data_i(s_data_i), .s_sel_o(s_sel_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
    .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_rty_i(s_rty_i)
`ifdef WB_DECODER_ERR_CAPTURE_EN
    , .err_addr_o(err_addr_o), .err_cause_o(err_cause_o)
`endif
  );

  // 10 ns clock.
  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Expected outputs for the current inputs given who owns the bus.
  function automatic void eval_model();
    int idx, tgt;
    bit routed;
    idx = int'(m_addr_i[25:24]);
    exp_cyc = '0; exp_stb = '0; exp_we = '0;
    exp_mdata = '0; exp_ack = 1'b0; exp_rty = 1'b0; exp_err = 1'b0;
    tgt = -1;
    routed = 1'b0;
    if (!rst_i && !mdl_inerr) begin
      if (mdl_owner >= 0) begin
        tgt = mdl_owner;
        routed = 1'b1;
      end else if (idx < NSL) begin
        tgt = idx;
        routed = m_cyc_i && m_stb_i;
      end
      if (tgt >= 0 && m_cyc_i) begin
        exp_cyc[tgt] = 1'b1;
        exp_we[tgt]  = m_we_i;
        exp_stb[tgt] = m_stb_i && !(mdl_owner >= 0 && idx != mdl_owner);
      end
      if (routed) begin
        exp_mdata = s_data_i[tgt*32 +: 32];
        exp_ack   = s_ack_i[tgt];
        exp_rty   = s_rty_i[tgt];
        exp_err   = s_err_i[tgt];
      end
    end
    exp_err = exp_err || (mdl_errflag && !rst_i);
  endfunction

  // Advance the model by one clock edge.
  task automatic step_model();
    int idx, cause;
    bit trm;
    idx = int'(m_addr_i[25:24]);
    cause = 0;
    if (mdl_inerr) begin
      if (!m_stb_i || !m_cyc_i) mdl_inerr = 1'b0;
    end else if (mdl_owner < 0) begin
      if (m_cyc_i && m_stb_i) begin
        if (idx < NSL) begin
          mdl_owner = idx;
          mdl_waits = 0;
        end else cause = 1;
      end
    end else begin
      trm = s_ack_i[mdl_owner] || s_err_i[mdl_owner] || s_rty_i[mdl_owner];
      if (!m_cyc_i) begin
        mdl_owner = -1;
        mdl_waits = 0;
      end else if (m_stb_i && idx != mdl_owner) cause = 2;
      else if (trm) mdl_waits = 0;
      else if (m_stb_i) begin
        mdl_waits++;
        if (mdl_waits == TMO) cause = 3;
      end
    end
    mdl_errflag = (cause != 0);
    if (cause != 0) begin
      mdl_inerr = 1'b1;
      mdl_owner = -1;
      mdl_waits = 0;
`ifdef WB_DECODER_ERR_CAPTURE_EN
      mdl_cap_addr  = m_addr_i;
      mdl_cap_cause = 2'(cause);
`endif
    end
  endtask

  // Model register update, reset asynchronously like the design.
  initial forever begin
    @(posedge clk_i or posedge rst_i);
    if (rst_i) begin
      mdl_owner = -1; mdl_inerr = 1'b0; mdl_errflag = 1'b0; mdl_waits = 0;
`ifdef WB_DECODER_ERR_CAPTURE_EN
      mdl_cap_addr = '0; mdl_cap_cause = '0;
`endif
    end else step_model();
  end

  // Compare every DUT output with the model on each falling edge.
  always @(negedge clk_i) begin
    if (checking) begin
      eval_model();
      checkOutput("s_cyc_o", 128'(s_cyc_o), 128'(exp_cyc));
      checkOutput("s_stb_o", 128'(s_stb_o), 128'(exp_stb));
      checkOutput("s_we_o", 128'(s_we_o), 128'(exp_we));
      checkOutput("m_data_o", 128'(m_data_o), 128'(exp_mdata));
      checkOutput("m_ack_o", 128'(m_ack_o), 128'(exp_ack));
      checkOutput("m_err_o", 128'(m_err_o), 128'(exp_err));
      checkOutput("m_rty_o", 128'(m_rty_o), 128'(exp_rty));
      checkOutput("s_addr_o", 128'(s_addr_o), 128'({3{m_addr_i[23:0]}}));
      checkOutput("s_data_o", 128'(s_data_o), 128'({3{m_data_i}}));
      checkOutput("s_sel_o", 128'(s_sel_o), 128'({3{m_sel_i}}));
`ifdef WB_DECODER_ERR_CAPTURE_EN
      checkOutput("err_addr_o", 128'(err_addr_o), 128'(mdl_cap_addr));
      checkOutput("err_cause_o", 128'(err_cause_o), 128'(mdl_cap_cause));
`endif
    end
  end

  // Drive one master cycle; the strobed slave answers with resp (0 none, 1 ack, 2 err, 3 rty).
  task automatic applyStimulus(input bit cyc, input bit stb, input bit we,
                               input logic [31:0] addr, input int resp);
    @(posedge clk_i);
    #1;
    m_cyc_i  = cyc;
    m_stb_i  = stb;
    m_we_i   = we;
    m_addr_i = addr;
    m_data_i = $urandom;
    m_sel_i  = 4'($urandom);
    s_data_i = fixed_data ? {32'hCCCC0002, 32'hBBBB0001, 32'hAAAA0000}
                          : {$urandom, $urandom, $urandom};
    s_ack_i = '0; s_err_i = '0; s_rty_i = '0;
    eval_model();
    for (int k = 0; k < NSL; k++) begin
      if (exp_stb[k]) begin
        case (resp)
          1: s_ack_i[k] = 1'b1;
          2: s_err_i[k] = 1'b1;
          3: s_rty_i[k] = 1'b1;
          default: ;
        endcase
      end
    end
    eval_model();
  endtask

  task automatic random_bus_cycle();
    int nbeats, base, idx, resp;
    bit dead, ended, done, we;
    logic [31:0] addr;
    nbeats = $urandom_range(1, 3);
    base = $urandom_range(0, 3);
    dead = ($urandom_range(0, 5) == 0);
    ended = 1'b0;
    for (int b = 0; b < nbeats && !ended; b++) begin
      idx = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 3)) : base;
      addr = {6'($urandom), 2'(idx), 24'($urandom)};
      we = 1'($urandom);
      done = 1'b0;
      for (int c = 0; c < 14 && !done; c++) begin
        resp = $urandom_range(0, 9);
        resp = dead ? 0 : (resp < 5) ? 0 : (resp < 8) ? 1 : (resp == 8) ? 2 : 3;
        applyStimulus(1'b1, 1'b1, we, addr, resp);
        if (exp_ack || exp_err || exp_rty) begin
          done = 1'b1;
          if (exp_err) ended = 1'b1;
        end
      end
      if (!done) ended = 1'b1;
      if (!ended && $urandom_range(0, 2) == 0) applyStimulus(1'b1, 1'b0, we, addr, 0);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, $urandom, 0);
    repeat ($urandom_range(0, 2)) applyStimulus(1'b0, 1'b0, 1'b0, $urandom, 0);
  endtask

  initial begin
    #1;
    rst_i = 1'b1;
    m_cyc_i = 1'b1; m_stb_i = 1'b1; m_addr_i = 32'h0000_0000;
    checking = 1'b1;

    // Reset: a master request must not reach any slave.
    @(negedge clk_i);
    checkOutput("reset s_cyc_o", 128'(s_cyc_o), 128'h0);
    checkOutput("reset s_stb_o", 128'(s_stb_o), 128'h0);
    checkOutput("reset m_ack_o", 128'(m_ack_o), 128'h0);
    checkOutput("reset m_err_o", 128'(m_err_o), 128'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 0);
    @(posedge clk_i);
    #1 rst_i = 1'b0;

    // Read 0x0100_0010, slave 1 acks on its third strobe cycle.
    fixed_data = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0100_0010, 0);
    @(negedge clk_i);
    checkOutput("rd s_stb_o", 128'(s_stb_o), 128'h2);
    checkOutput("rd s_addr_o[1]", 128'(s_addr_o[47:24]), 128'h000010);
    checkOutput("rd ack early", 128'(m_ack_o), 128'h0);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0100_0010, 0);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0100_0010, 1);
    @(negedge clk_i);
    checkOutput("rd m_ack_o", 128'(m_ack_o), 128'h1);
    checkOutput("rd m_data_o", 128'(m_data_o), 128'hBBBB0001);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 0);
    @(negedge clk_i);
    checkOutput("rd ack after", 128'(m_ack_o), 128'h0);

    // Unmapped access to index 3.
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0300_0000, 0);
    @(negedge clk_i);
    checkOutput("dec s_stb_o", 128'(s_stb_o), 128'h0);
    checkOutput("dec err early", 128'(m_err_o), 128'h0);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0300_0000, 0);
    @(negedge clk_i);
    checkOutput("dec m_err_o", 128'(m_err_o), 128'h1);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0300_0000, 0);
    @(negedge clk_i);
    checkOutput("dec err once", 128'(m_err_o), 128'h0);
`ifdef WB_DECODER_ERR_CAPTURE_EN
    checkOutput("dec cause", 128'(err_cause_o), 128'h1);
    checkOutput("dec addr", 128'(err_addr_o), 128'h0300_0000);
`endif
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 0);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0000_0020, 1);
    @(negedge clk_i);
    checkOutput("dec then ack", 128'(m_ack_o), 128'h1);
    checkOutput("dec then stb", 128'(s_stb_o), 128'h1);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 0);

    // Watchdog: slave 2 never answers.
    for (int c = 0; c <= 9; c++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h0200_0000, 0);
      @(negedge clk_i);
      if (c == 8) begin
        checkOutput("wd stb c8", 128'(s_stb_o), 128'h4);
        checkOutput("wd err c8", 128'(m_err_o), 128'h0);
      end
      if (c == 9) begin
        checkOutput("wd err c9", 128'(m_err_o), 128'h1);
        checkOutput("wd stb c9", 128'(s_stb_o), 128'h0);
      end
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 0);
`ifdef WB_DECODER_ERR_CAPTURE_EN
    @(negedge clk_i);
    checkOutput("wd cause", 128'(err_cause_o), 128'h3);
`endif

    // Select change inside one bus cycle.
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h0000_0004, 1);
    @(negedge clk_i);
    checkOutput("sc beat1 ack", 128'(m_ack_o), 128'h1);
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h0200_0008, 0);
    @(negedge clk_i);
    checkOutput("sc s_stb_o", 128'(s_stb_o), 128'h0);
    checkOutput("sc err early", 128'(m_err_o), 128'h0);
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h0200_0008, 0);
    @(negedge clk_i);
    checkOutput("sc m_err_o", 128'(m_err_o), 128'h1);
    checkOutput("sc s_stb_o late", 128'(s_stb_o), 128'h0);
`ifdef WB_DECODER_ERR_CAPTURE_EN
    checkOutput("sc cause", 128'(err_cause_o), 128'h2);
    checkOutput("sc addr", 128'(err_addr_o), 128'h0200_0008);
`endif
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 0);

    // Ack lands on the cycle the watchdog would fire.
    for (int c = 0; c <= 8; c++) applyStimulus(1'b1, 1'b1, 1'b0, 32'h0000_0040, (c == 8) ? 1 : 0);
    @(negedge clk_i);
    checkOutput("race m_ack_o", 128'(m_ack_o), 128'h1);
    checkOutput("race m_err_o", 128'(m_err_o), 128'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 0);
    @(negedge clk_i);
    checkOutput("race err after", 128'(m_err_o), 128'h0);

    // Reset asserted between edges in the middle of an access.
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0100_0000, 0);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0100_0000, 0);
    @(negedge clk_i);
    checkOutput("mid s_stb_o", 128'(s_stb_o), 128'h2);
    #2 rst_i = 1'b1;
    #1;
    checkOutput("mid rst s_cyc_o", 128'(s_cyc_o), 128'h0);
    checkOutput("mid rst s_stb_o", 128'(s_stb_o), 128'h0);
    checkOutput("mid rst m_ack_o", 128'(m_ack_o), 128'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 0);
    @(posedge clk_i);
    #1 rst_i = 1'b0;
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0200_0000, 1);
    @(negedge clk_i);
    checkOutput("post rst ack", 128'(m_ack_o), 128'h1);
    checkOutput("post rst stb", 128'(s_stb_o), 128'h4);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 0);

    // Randomized bus cycles.
    fixed_data = 1'b0;
    for (int n = 0; n < 120; n++) random_bus_cycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 0);
    @(negedge clk_i);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
